// File: rtl/barrett_red_stream.sv
// Streaming Barrett reducer: r = a mod n with runtime-loadable n and k = floor(2^SHIFT/n).
// Four-stage pipeline with valid/ready back-pressure and an opaque tag carried alongside each operand.
module barrett_red_stream #(
   parameter int A_WIDTH   = 32,
   parameter int N_WIDTH   = 16,
   parameter int K_WIDTH   = 18,
   parameter int SHIFT     = 32,
   parameter int TAG_WIDTH = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 cfg_load,
   input  logic [N_WIDTH-1:0]   cfg_n,
   input  logic [K_WIDTH-1:0]   cfg_k,
   output logic                 cfg_err,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [A_WIDTH-1:0]   in_a,
   input  logic [TAG_WIDTH-1:0] in_tag,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [N_WIDTH-1:0]   out_r,
   output logic [TAG_WIDTH-1:0] out_tag,
   output logic                 busy
);

   localparam int P_WIDTH = A_WIDTH + K_WIDTH;
   localparam int C_WIDTH = N_WIDTH + 2;

   logic                 cfg_valid_reg;
   logic                 cfg_err_reg;
   logic [N_WIDTH-1:0]   n_reg;
   logic [K_WIDTH-1:0]   k_reg;

   logic                 s1_valid_reg;
   logic [P_WIDTH-1:0]   s1_p_reg;
   logic [C_WIDTH-1:0]   s1_a_reg;
   logic [TAG_WIDTH-1:0] s1_tag_reg;

   logic                 s2_valid_reg;
   logic [C_WIDTH-1:0]   s2_m_reg;
   logic [C_WIDTH-1:0]   s2_a_reg;
   logic [TAG_WIDTH-1:0] s2_tag_reg;

   logic                 s3_valid_reg;
   logic [C_WIDTH-1:0]   s3_c_reg;
   logic [TAG_WIDTH-1:0] s3_tag_reg;

   logic                 out_valid_reg;
   logic [N_WIDTH-1:0]   out_r_reg;
   logic [TAG_WIDTH-1:0] out_tag_reg;

   logic                 adv;
   logic                 accept;
   logic [P_WIDTH-1:0]   p_next;
   logic [C_WIDTH-1:0]   q_lo;
   logic [C_WIDTH-1:0]   m_next;
   logic [C_WIDTH-1:0]   n_ext;
   logic [C_WIDTH-1:0]   two_n;
   logic [N_WIDTH-1:0]   r_next;

   assign adv      = ~out_valid_reg | out_ready;
   assign in_ready = adv & cfg_valid_reg & ~cfg_load;
   assign accept   = in_valid & in_ready;
   assign busy     = s1_valid_reg | s2_valid_reg | s3_valid_reg | out_valid_reg;

   assign n_ext  = C_WIDTH'(n_reg);
   assign two_n  = {1'b0, n_reg, 1'b0};
   assign p_next = P_WIDTH'(in_a) * P_WIDTH'(k_reg);
   // Only the low C_WIDTH bits of q matter: m is taken modulo 2^C_WIDTH anyway.
   assign q_lo   = C_WIDTH'(s1_p_reg >> SHIFT);
   assign m_next = q_lo * n_ext;

   // Final correction: both candidate subtractions are evaluated side by side, then selected.
   always_comb begin
      r_next = N_WIDTH'(s3_c_reg);
      if (s3_c_reg >= two_n) begin
         r_next = N_WIDTH'(s3_c_reg - two_n);
      end else if (s3_c_reg >= n_ext) begin
         r_next = N_WIDTH'(s3_c_reg - n_ext);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cfg_valid_reg <= 1'b0;
         cfg_err_reg   <= 1'b0;
         n_reg         <= '0;
         k_reg         <= '0;
      end else begin
         cfg_err_reg <= 1'b0;
         if (cfg_load) begin
            // n/k may only change on an empty pipeline so no operand mixes two moduli.
            if (!busy && cfg_n >= N_WIDTH'(2)) begin
               n_reg         <= cfg_n;
               k_reg         <= cfg_k;
               cfg_valid_reg <= 1'b1;
            end else begin
               cfg_err_reg <= 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_valid_reg  <= 1'b0;
         s1_p_reg      <= '0;
         s1_a_reg      <= '0;
         s1_tag_reg    <= '0;
         s2_valid_reg  <= 1'b0;
         s2_m_reg      <= '0;
         s2_a_reg      <= '0;
         s2_tag_reg    <= '0;
         s3_valid_reg  <= 1'b0;
         s3_c_reg      <= '0;
         s3_tag_reg    <= '0;
         out_valid_reg <= 1'b0;
         out_r_reg     <= '0;
         out_tag_reg   <= '0;
      end else if (adv) begin
         s1_valid_reg  <= accept;
         s1_p_reg      <= p_next;
         s1_a_reg      <= C_WIDTH'(in_a);
         s1_tag_reg    <= in_tag;

         s2_valid_reg  <= s1_valid_reg;
         s2_m_reg      <= m_next;
         s2_a_reg      <= s1_a_reg;
         s2_tag_reg    <= s1_tag_reg;

         s3_valid_reg  <= s2_valid_reg;
         s3_c_reg      <= s2_a_reg - s2_m_reg;
         s3_tag_reg    <= s2_tag_reg;

         out_valid_reg <= s3_valid_reg;
         out_r_reg     <= r_next;
         out_tag_reg   <= s3_tag_reg;
      end
   end

   assign cfg_err   = cfg_err_reg;
   assign out_valid = out_valid_reg;
   assign out_r     = out_r_reg;
   assign out_tag   = out_tag_reg;

endmodule

// File: doc/barrett_red_stream.md
Name: barrett_red_stream

Overview:
- Parametrised, fully pipelined Barrett reducer: computes r = a mod n for a streaming sequence of A_WIDTH-bit operands.
- Modulus n and Barrett constant k = floor(2^SHIFT / n) are runtime-loadable.
- Uses a valid/ready handshake with back-pressure, throughput of 1 result per cycle, and carries an opaque tag alongside each operand.
- Sits between polynomial/sampler datapaths and memory writers in the HQC cores; one instance serves any parameter set.

Parameters:
- A_WIDTH, 32, operand width; requires a < 2^SHIFT.
- N_WIDTH, 16, modulus/result width (CLOG2 of largest n).
- K_WIDTH, 18, Barrett constant width (hqc128 needs 18).
- SHIFT, 32, Barrett shift; must satisfy SHIFT >= A_WIDTH.
- TAG_WIDTH, 8, sideband tag width.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- cfg_load  in  1  load request for cfg_n/cfg_k
- cfg_n  in  N_WIDTH  modulus
- cfg_k  in  K_WIDTH  floor(2^SHIFT/cfg_n), precomputed by software
- cfg_err  out  1  one-cycle pulse: cfg_load rejected
- in_valid  in  1  operand valid
- in_ready  out  1  block accepts operand
- in_a  in  A_WIDTH  operand
- in_tag  in  TAG_WIDTH  sideband tag
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- out_r  out  N_WIDTH  a mod n
- out_tag  out  TAG_WIDTH  tag of the same operand
- busy  out  1  any pipeline stage holds valid data

Behaviour:

Reset:
- rst asserted (async) clears all stage valids, cfg_valid, and cfg_err.
- Reset values: out_valid=0, in_ready=0, busy=0, cfg_err=0.
- out_r, out_tag and n/k registers reset to 0.
- Reset mid-stream discards in-flight data; no output after release until the block is reconfigured.

Config:
- cfg_load with busy=0 and cfg_n>=2 registers n,k on that edge; cfg_valid=1 from the next cycle.
- cfg_load with busy=1 or cfg_n<2: registers unchanged, cfg_err=1 for the next cycle only.
- Reloading is legal; the pipeline must be drained first.

Handshake:
- adv = ~out_valid | out_ready.
- in_ready = adv & cfg_valid & ~cfg_load.
- Accept when in_valid & in_ready.
- All stages shift together only when adv=1; when adv=0, every stage and the outputs hold.
- out_r/out_tag stay stable while out_valid & ~out_ready.
- No drop and no duplication; order is preserved.

Pipeline (4 stages, latency 4 cycles from accept to out_valid with no stall):
- S1: p = a*k, width A_WIDTH+K_WIDTH; register a, tag.
- S2: q = p >> SHIFT; m = (q*n) truncated to N_WIDTH+2 bits.
- S3: c = a[N_WIDTH+1:0] - m, mod 2^(N_WIDTH+2). Guaranteed 0 <= c < 3n because k <= 2^SHIFT/n and a < 2^SHIFT.
- S4 (output register): r = c-2n if c>=2n; else c-n if c>=n; else c. Compute with parallel compares, not sequential.
- A bubble (no accept) advances as an invalid slot.
- busy = OR of S1..S3 valids and out_valid.

Boundaries:
- a=0 gives 0; a=n-1 gives n-1; a=n gives 0; a=2^A_WIDTH-1 gives the correct residue.
- out_ready held low with the pipeline full: in_ready=0, contents frozen.
- Simultaneous cfg_load and in_valid: the operand is not accepted (in_ready=0), and the config rules above apply.
- An incorrect cfg_k is not detected; the result is unspecified but the handshake stays correct.

Test Plan:
1. Load n=57637, k=74517; stream a=0, 57636, 57637, 4294967295 with out_ready=1 -> outputs 0, 57636, 0, 30966 on consecutive cycles; first out_valid 4 cycles after first accept; tags echoed in order.
2. Load n=17669, k=243079; stream 1000 random 32-bit a with tags 0..255 wrapping -> every out_r equals a mod 17669 against the model; throughput 1/cycle.
3. Continuous stream with out_ready low for 3 cycles mid-stream -> in_ready=0 during the stall; out_r/out_tag held; no loss or reorder; afterwards results resume 1/cycle.
4. cfg_load while busy=1, then cfg_load with cfg_n=1 -> cfg_err pulses one cycle each time; the old n still applies to subsequent results.
5. Assert rst with 3 operands in flight, release, then send in_valid=1 without reconfiguring -> out_valid=0 immediately; in_ready stays 0 until cfg_load; reload n=35851, k=119800, a=100000 -> 28298.
6. Random in_valid/out_ready toggling (50% each) over 5000 operands, n=57637 -> scoreboard matches exactly.
